// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM states, oversampling constants and
// the data-width clamp.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_TICK   = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rx_state_e;

  // Frames carry 5..8 data bits; out-of-range requests saturate to the nearest legal width.
  function automatic logic [3:0] clamp_bits(input logic [3:0] n);
    if (n < 4'd5) return 4'd5;
    if (n > 4'd8) return 4'd8;
    return n;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous level input; both flops preset to 1 so an
// idle-high line is seen as idle straight out of reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 5..8 data bits, optional parity, one or two stop bits.
// All bit timing is derived from the external sample_tick strobe.
module uart_rx #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       sample_tick,
  input  logic       stop_bits,
  input  logic       parity_en,
  input  logic       parity_even,
  input  logic [3:0] data_bits,
  input  logic       enable,
  output logic       enable_sample,
  output logic       data_ready,
  output logic [7:0] data_out,
  output logic       parity_err,
  output logic       framing_err
);
  import uart_pkg::*;

  localparam logic [3:0] LastTick = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] MidTick  = 4'(MID_TICK - 1);

  logic rxd_s;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxd_s)
  );

  rx_state_e  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shreg_q, shreg_d;
  logic [3:0] nbits_q, nbits_d;
  logic       par_en_q, par_en_d;
  logic       par_even_q, par_even_d;
  logic       two_stop_q, two_stop_d;
  logic       stop2_q, stop2_d;
  logic       pe_q, pe_d;
  logic       fe_q, fe_d;
  logic [7:0] data_out_q, data_out_d;
  logic       pe_out_q, pe_out_d;
  logic       fe_out_q, fe_out_d;
  logic       ready_q, ready_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = sample_tick ? cnt_q + 4'd1 : cnt_q;
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    nbits_d    = nbits_q;
    par_en_d   = par_en_q;
    par_even_d = par_even_q;
    two_stop_d = two_stop_q;
    stop2_d    = stop2_q;
    pe_d       = pe_q;
    fe_d       = fe_q;
    data_out_d = data_out_q;
    pe_out_d   = pe_out_q;
    fe_out_d   = fe_out_q;
    ready_d    = 1'b0;

    if (state_q != StIdle && !enable) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (enable && !rxd_s) begin
            state_d    = StStart;
            cnt_d      = '0;
            bit_idx_d  = '0;
            shreg_d    = '0;
            stop2_d    = 1'b0;
            pe_d       = 1'b0;
            fe_d       = 1'b0;
            nbits_d    = clamp_bits(data_bits);
            par_en_d   = parity_en;
            par_even_d = parity_even;
            two_stop_d = stop_bits;
          end
        end
        StStart: begin
          if (sample_tick && cnt_q == MidTick) begin
            if (!rxd_s) begin
              state_d = StData;
              cnt_d   = '0;
            end else begin
              state_d = StIdle;
            end
          end
        end
        StData: begin
          if (sample_tick && cnt_q == LastTick) begin
            shreg_d[bit_idx_q] = rxd_s;
            if ({1'b0, bit_idx_q} == nbits_q - 4'd1) begin
              state_d = par_en_q ? StParity : StStop;
              cnt_d   = '0;
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
            end
          end
        end
        StParity: begin
          if (sample_tick && cnt_q == LastTick) begin
            // Unused upper shreg bits are zero, so reducing all 8 bits is safe.
            pe_d    = rxd_s ^ (^shreg_q) ^ ~par_even_q;
            state_d = StStop;
            cnt_d   = '0;
          end
        end
        StStop: begin
          if (sample_tick && cnt_q == LastTick) begin
            if (two_stop_q && !stop2_q) begin
              stop2_d = 1'b1;
              fe_d    = fe_q | ~rxd_s;
            end else begin
              state_d    = StIdle;
              ready_d    = 1'b1;
              data_out_d = shreg_q;
              pe_out_d   = pe_q;
              fe_out_d   = fe_q | ~rxd_s;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      nbits_q    <= 4'd8;
      par_en_q   <= 1'b0;
      par_even_q <= 1'b0;
      two_stop_q <= 1'b0;
      stop2_q    <= 1'b0;
      pe_q       <= 1'b0;
      fe_q       <= 1'b0;
      data_out_q <= '0;
      pe_out_q   <= 1'b0;
      fe_out_q   <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
      nbits_q    <= nbits_d;
      par_en_q   <= par_en_d;
      par_even_q <= par_even_d;
      two_stop_q <= two_stop_d;
      stop2_q    <= stop2_d;
      pe_q       <= pe_d;
      fe_q       <= fe_d;
      data_out_q <= data_out_d;
      pe_out_q   <= pe_out_d;
      fe_out_q   <= fe_out_d;
      ready_q    <= ready_d;
    end
  end

  assign enable_sample = (state_q != StIdle);
  assign data_ready    = ready_q;
  assign data_out      = data_out_q;
  assign parity_err    = pe_out_q;
  assign framing_err   = fe_out_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frames are built bit by bit from their data/config and the expected
// {data, parity_err, framing_err} of each frame is queued and matched against observed pulses.
module tb_uart_rx;

  localparam int TDIV = 4;  // clocks per sample_tick

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       sample_tick = 1'b0;
  logic       stop_bits = 1'b0;
  logic       parity_en = 1'b0;
  logic       parity_even = 1'b0;
  logic [3:0] data_bits = 4'd8;
  logic       enable = 1'b1;
  logic       enable_sample;
  logic       data_ready;
  logic [7:0] data_out;
  logic       parity_err;
  logic       framing_err;

  int          total = 0;
  int          bad = 0;
  int unsigned div = 0;
  logic [9:0]  exp_q[$];
  logic [9:0]  got_q[$];

  uart_rx #(.OVERSAMPLE(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .rxd           (rxd),
    .sample_tick   (sample_tick),
    .stop_bits     (stop_bits),
    .parity_en     (parity_en),
    .parity_even   (parity_even),
    .data_bits     (data_bits),
    .enable        (enable),
    .enable_sample (enable_sample),
    .data_ready    (data_ready),
    .data_out      (data_out),
    .parity_err    (parity_err),
    .framing_err   (framing_err)
  );

  initial forever #5 clk = ~clk;

  // Free-running tick source, gated by the receiver's request.
  initial forever begin
    @(posedge clk);
    #1;
    div = (div + 1) % TDIV;
    sample_tick = enable_sample && (div == 0);
  end

  initial forever begin
    @(negedge clk);
    if (data_ready) got_q.push_back({data_out, parity_err, framing_err});
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic send_level(input logic v, input int nticks);
    rxd = v;
    repeat (nticks * TDIV) @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  // bad_stop: 0 none, else index of the stop bit sent low. hold_low keeps the line low after
  // a bad last stop; scramble randomizes config inputs once the frame is underway.
  task automatic send_frame(input logic [7:0] data, input logic [3:0] nb_cfg, input logic pen,
                            input logic peven, input logic two_stop, input logic bad_par,
                            input int bad_stop, input int start_len, input bit hold_low,
                            input bit scramble);
    int         n;
    int         nstop;
    logic [7:0] d;
    logic       pbit;
    n = (nb_cfg < 4'd5) ? 5 : (nb_cfg > 4'd8) ? 8 : int'(nb_cfg);
    d = data & 8'((1 << n) - 1);
    data_bits   = nb_cfg;
    parity_en   = pen;
    parity_even = peven;
    stop_bits   = two_stop;
    send_level(1'b0, start_len);
    if (scramble) {data_bits, parity_en, parity_even, stop_bits} = 7'($urandom);
    for (int i = 0; i < n; i++) send_level(d[i], 16);
    if (pen) begin
      pbit = (^d) ^ ~peven ^ bad_par;
      send_level(pbit, 16);
    end
    nstop = two_stop ? 2 : 1;
    for (int i = 1; i <= nstop; i++) begin
      if (bad_stop != i) send_level(1'b1, 16);
      else if (i == nstop && hold_low) send_level(1'b0, 16);
      else if (i == nstop) begin
        send_level(1'b0, 12);
        send_level(1'b1, 4);
      end else send_level(1'b0, 16);
    end
    rxd = hold_low ? rxd : 1'b1;
    exp_q.push_back({d, pen & bad_par, 1'(bad_stop != 0)});
  endtask

  task automatic flush_check(input string tag);
    idle_cycles(3 * 16 * TDIV);
    check_eq({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0)
      check_eq(tag, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    exp_q.delete();
    got_q.delete();
    check_eq({tag, "_es"}, 32'(enable_sample), 32'(0));
  endtask

  initial begin
    logic [7:0] rd;
    logic [3:0] rnb;
    logic       rpen, rpev, rts, rbp;
    int         rbs, gap;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_data", 32'(data_out), 32'(0));
    check_eq("rst_flags", 32'({data_ready, parity_err, framing_err}), 32'(0));
    check_eq("rst_es", 32'(enable_sample), 32'(0));
    rst = 1'b0;
    idle_cycles(20);

    send_frame(8'hA5, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 0, 16, 1'b0, 1'b0);
    flush_check("8n1_a5");

    send_frame(8'h3C, 4'd8, 1'b1, 1'b1, 1'b0, 1'b1, 0, 16, 1'b0, 1'b0);
    flush_check("8e1_badpar");

    send_frame(8'h5A, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1, 16, 1'b1, 1'b0);
    send_frame(8'hC3, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 0, 8, 1'b0, 1'b0);
    flush_check("fe_restart");

    for (int i = 0; i < 3; i++)
      send_frame(8'h55, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 0, 16, 1'b0, 1'b0);
    flush_check("b2b_55");

    send_level(1'b0, 3);
    send_level(1'b1, 4);
    flush_check("glitch");
    check_eq("glitch_hold", 32'(data_out), 32'(8'h55));

    // Abort by enable: start plus two data bits, then drop enable.
    data_bits = 4'd8;
    parity_en = 1'b0;
    stop_bits = 1'b0;
    send_level(1'b0, 16);
    send_level(1'b0, 16);
    send_level(1'b1, 16);
    enable = 1'b0;
    idle_cycles(2);
    check_eq("abort_es", 32'(enable_sample), 32'(0));
    send_level(1'b1, 16 * 8);
    enable = 1'b1;
    flush_check("abort");
    check_eq("abort_hold", 32'(data_out), 32'(8'h55));

    // Reset mid-frame, then a 7O2 frame.
    send_level(1'b0, 16);
    send_level(1'b1, 16);
    send_level(1'b0, 8);
    rst = 1'b1;
    rxd = 1'b1;
    #1;
    check_eq("rst_async_es", 32'(enable_sample), 32'(0));
    idle_cycles(3);
    check_eq("rst_mid_data", 32'(data_out), 32'(0));
    rst = 1'b0;
    send_level(1'b1, 32);
    flush_check("rst_abort");
    send_frame(8'h41, 4'd7, 1'b1, 1'b0, 1'b1, 1'b0, 0, 16, 1'b0, 1'b0);
    flush_check("7o2_41");

    for (int k = 0; k < 30; k++) begin
      rd   = 8'($urandom);
      rnb  = 4'($urandom);
      rpen = 1'($urandom);
      rpev = 1'($urandom);
      rts  = 1'($urandom);
      rbp  = ($urandom_range(0, 3) == 0);
      rbs  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, rts ? 2 : 1)) : 0;
      send_frame(rd, rnb, rpen, rpev, rts, rbp, rbs, 16, 1'b0, 1'b1);
      // A short low last stop triggers a false start that must resolve before the next frame.
      gap = int'($urandom_range(0, 20)) + ((rbs == (rts ? 2 : 1)) ? 16 * TDIV : 0);
      idle_cycles(gap);
      if (k % 5 == 4) flush_check("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter OVERSAMPLE, default 16, ticks per bit period.
REQ-002 clk  in  1  single rising-edge clock.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 rxd  in  1  serial line, idle high, LSB first.
REQ-005 sample_tick  in  1  one-clk strobe at 16x baud; only produced externally while enable_sample=1; first tick comes an arbitrary number of cycles after enable_sample rises.
REQ-006 stop_bits  in  1  0=one stop bit, 1=two stop bits.
REQ-007 parity_en  in  1  1=parity bit follows data.
REQ-008 parity_even  in  1  1=even, 0=odd parity.
REQ-009 data_bits  in  4  data bits per frame; 5..8 valid, <5 treated as 5, >8 treated as 8.
REQ-010 enable  in  1  receiver enable.
REQ-011 enable_sample  out  1  requests tick generation; high in every non-IDLE state.
REQ-012 data_ready  out  1  one-clk pulse when a frame completes.
REQ-013 data_out  out  8  received data, right-justified, unused upper bits 0.
REQ-014 parity_err  out  1  parity mismatch for last frame.
REQ-015 framing_err  out  1  stop bit sampled low for last frame.

Function
REQ-016 States SHALL be IDLE, START, DATA, PARITY, STOP; all counting uses sample_tick only.
REQ-017 rxd SHALL pass through a 2-flop synchronizer before use.
REQ-018 IDLE: enable_sample=0; when enable=1 and the synchronized rxd is low (level, not edge), go to START and clear the tick counter.
REQ-019 START: after 8 ticks sample rxd; low -> clear the counter, go to DATA; high -> false start, return to IDLE.
REQ-020 DATA: sample every 16 ticks (mid-bit) and shift into bit position 0..data_bits-1; after the last bit go to PARITY if parity_en, else STOP.
REQ-021 PARITY: sample after 16 ticks; expected bit = XOR of data bits, inverted when parity_even=0; mismatch flags parity_err.
REQ-022 STOP: sample after 16 ticks; with stop_bits=1 sample a second stop 16 ticks later; any low sample flags framing_err.
REQ-023 On the clk after the final stop sample: data_ready=1 for one cycle; data_out, parity_err and framing_err update in the same cycle; state returns to IDLE.
REQ-024 data_out/parity_err/framing_err SHALL hold until the next data_ready; when parity_en=0, parity_err=0.
REQ-025 After a framing error with rxd still low, IDLE SHALL immediately treat the low level as a new start bit.
REQ-026 enable deasserted mid-frame: abort to IDLE next clk, no data_ready, outputs unchanged.
REQ-027 Config inputs SHALL be sampled on leaving IDLE and held for the frame.
REQ-028 Tick counter SHALL be 4 bits, wrap 15->0, cleared on every state entry.

Reset
REQ-029 rst=1 SHALL asynchronously force IDLE and clear the counters and shift register; data_out=0, data_ready=0, parity_err=0, framing_err=0, enable_sample=0; synchronizer flops preset to 1.
REQ-030 Reset mid-frame SHALL discard the frame without asserting data_ready.

Structure
REQ-031 Package uart_pkg SHALL hold the state enum, OVERSAMPLE=16 and MID_TICK=8.
REQ-032 The rxd synchronizer SHALL be a sub-module named sync_2ff; all else stays in uart_rx.

Verification
REQ-033 8N1, byte 0xA5, stop=1 -> data_ready pulse, data_out=0xA5, PE=0, FE=0.
REQ-034 8E1, byte 0x3C, parity bit sent as 1 (correct value is 0) -> data_out=0x3C, PE=1, FE=0.
REQ-035 8N1, byte 0x5A, stop bit 0 and rxd left low -> data_out=0x5A, PE=0, FE=1; the next frame, started immediately, is received correctly.
REQ-036 Three back-to-back 8N1 frames of 0x55 -> three data_ready pulses, each 0x55, no errors.
REQ-037 A 3-tick low glitch in IDLE -> false start, no data_ready, enable_sample back to 0.
REQ-038 rst asserted mid-frame, then 7O2 byte 0x41 -> no pulse for the aborted frame; data_out=0x41, PE=0, FE=0.
